// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Shared encodings for the memory-access stage: data-memory
//               access widths, write-back source select, FSM states, and an
//               alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    // Width of the program counter carried down the pipeline
    localparam int IM_ADDR_BIT = 32;

    // Data-memory access width / sign encodings
    localparam int DM_OP_BIT = 3;
    localparam logic [DM_OP_BIT-1:0] DM_OP_WD = 3'd0;
    localparam logic [DM_OP_BIT-1:0] DM_OP_UH = 3'd1;
    localparam logic [DM_OP_BIT-1:0] DM_OP_SH = 3'd2;
    localparam logic [DM_OP_BIT-1:0] DM_OP_UB = 3'd3;
    localparam logic [DM_OP_BIT-1:0] DM_OP_SB = 3'd4;

    // Write-back source select
    localparam int MUX_RF_DATAW_BIT = 2;
    localparam logic [MUX_RF_DATAW_BIT-1:0] DATAW_ALU = 2'd0;
    localparam logic [MUX_RF_DATAW_BIT-1:0] DATAW_DM  = 2'd1;
    localparam logic [MUX_RF_DATAW_BIT-1:0] DATAW_PC4 = 2'd2;

    // Access FSM states
    localparam int STATE_BIT = 2;
    localparam logic [STATE_BIT-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_BIT-1:0] ST_BUSY = 2'd1;
    localparam logic [STATE_BIT-1:0] ST_DONE = 2'd2;

    // Words need a 4-byte boundary, halves a 2-byte boundary, bytes never fault
    function automatic logic is_aligned(input logic [DM_OP_BIT-1:0] op,
                                        input logic [1:0]           addr_lo);
        logic ok;
        ok = 1'b1;
        case (op)
            DM_OP_UH, DM_OP_SH: ok = (addr_lo[0] == 1'b0);
            DM_OP_UB, DM_OP_SB: ok = 1'b1;
            default:            ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_dm_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_align
// Description : Byte-lane steering for data memory. Produces store byte
//               enables and replicated store data, and extracts/extends the
//               addressed lane of the raw read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]           addr_lo,
    input  logic [DM_OP_BIT-1:0] op,
    input  logic [31:0]          store_data,
    input  logic [31:0]          rdata_raw,
    output logic [3:0]           be,
    output logic [31:0]          wdata,
    output logic [31:0]          load_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Select the half and byte lanes addressed by the low address bits
    always_comb begin
        w_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        case (addr_lo)
            2'd0:    w_byte = rdata_raw[7:0];
            2'd1:    w_byte = rdata_raw[15:8];
            2'd2:    w_byte = rdata_raw[23:16];
            default: w_byte = rdata_raw[31:24];
        endcase
    end

    // Store enables/data replicated across lanes, and load extension by op
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata_raw;
        case (op)
            DM_OP_UH, DM_OP_SH: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = (op == DM_OP_SH) ? {{16{w_half[15]}}, w_half}
                                             : {16'h0000, w_half};
            end
            DM_OP_UB, DM_OP_SB: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (op == DM_OP_SB) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h000000, w_byte};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata_raw;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage core. Runs loads/stores over a
//               req/ack data bus, stalls upstream while an access is in
//               flight, flags misalignment and ack timeouts, and selects the
//               write-back data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DM_ADDR_BIT = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IM_ADDR_BIT-1:0]      pc_4,
    input  logic [31:0]                 alu_data_res,
    input  logic [31:0]                 regfile_data_b,
    input  logic [DM_OP_BIT-1:0]        datamem_op,
    input  logic                        datamem_w_en,
    input  logic [MUX_RF_DATAW_BIT-1:0] mux_regfile_data_w,
    input  logic                        regfile_w_en,
    input  logic                        halt,
    output logic                        stall,
    output logic [31:0]                 wb_data,
    output logic                        wb_w_en,
    output logic                        dm_req,
    output logic                        dm_we,
    output logic [DM_ADDR_BIT-1:0]      dm_addr,
    output logic [3:0]                  dm_be,
    output logic [31:0]                 dm_wdata,
    input  logic                        dm_ack,
    input  logic [31:0]                 dm_rdata,
    output logic                        misalign_err,
    output logic                        bus_err,
    output logic                        halted
);

    localparam int CNT_BIT = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_BIT-1:0] C_CNT_LAST = CNT_BIT'(ACK_TIMEOUT - 1);

    logic [STATE_BIT-1:0] r_state;
    logic [STATE_BIT-1:0] w_state_nxt;
    logic [CNT_BIT-1:0]   r_cnt;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic                 r_halted;

    logic        w_mem_op;
    logic        w_aligned;
    logic        w_access;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;
    logic [31:0] w_pass;
    logic [31:0] w_addr_word;

    dm_lane_align u_lane_align (
        .addr_lo    (alu_data_res[1:0]),
        .op         (datamem_op),
        .store_data (regfile_data_b),
        .rdata_raw  (dm_rdata),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_data  (w_load_ext)
    );

    // Decode whether this instruction starts a bus access; held reset keeps
    // the combinational stall/error outputs quiet
    always_comb begin
        w_mem_op   = datamem_w_en | (mux_regfile_data_w == DATAW_DM);
        w_aligned  = is_aligned(datamem_op, alu_data_res[1:0]);
        w_access   = w_mem_op & ~r_halted & w_aligned & rst_n;
        w_misalign = w_mem_op & ~r_halted & ~w_aligned & rst_n
                   & (r_state == ST_IDLE);
        w_pass     = (mux_regfile_data_w == DATAW_PC4) ? pc_4 : alu_data_res;
    end

    // State register, ack-timeout counter and captured load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        r_rdata <= w_load_ext;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Sticky halt, set only when the halt instruction sits in an idle stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if ((r_state == ST_IDLE) && halt) begin
            r_halted <= 1'b1;
        end
    end

    // Next-state, stall and write-back selection
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        wb_data     = w_pass;
        wb_w_en     = regfile_w_en;
        bus_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    stall       = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
                if (w_misalign) begin
                    wb_w_en = 1'b0;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (dm_ack || (r_cnt == C_CNT_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_data     = r_err ? 32'h0000_0000 : r_rdata;
                w_state_nxt = ST_IDLE;
                if (r_err) begin
                    bus_err = 1'b1;
                    wb_w_en = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus drive: request decodes straight from BUSY; address/data follow the
    // inputs, which the stall holds stable for the whole access
    always_comb begin
        w_addr_word  = {alu_data_res[31:2], 2'b00};
        dm_req       = (r_state == ST_BUSY);
        dm_we        = dm_req & datamem_w_en;
        dm_be        = dm_req ? w_be : 4'b0000;
        dm_addr      = w_addr_word[DM_ADDR_BIT-1:0];
        dm_wdata     = w_wdata;
        misalign_err = w_misalign;
        halted       = r_halted;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_4;
    logic [31:0] alu_data_res;
    logic [31:0] regfile_data_b;
    logic [2:0]  datamem_op;
    logic        datamem_w_en;
    logic [1:0]  mux_regfile_data_w;
    logic        regfile_w_en;
    logic        halt;
    logic        stall;
    logic [31:0] wb_data;
    logic        wb_w_en;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        misalign_err;
    logic        bus_err;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.DM_ADDR_BIT(32), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc_4(pc_4), .alu_data_res(alu_data_res),
        .regfile_data_b(regfile_data_b), .datamem_op(datamem_op),
        .datamem_w_en(datamem_w_en), .mux_regfile_data_w(mux_regfile_data_w),
        .regfile_w_en(regfile_w_en), .halt(halt), .stall(stall),
        .wb_data(wb_data), .wb_w_en(wb_w_en), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .misalign_err(misalign_err), .bus_err(bus_err),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_nop();
        alu_data_res       = 32'h0;
        regfile_data_b     = 32'h0;
        datamem_op         = DM_OP_WD;
        datamem_w_en       = 1'b0;
        mux_regfile_data_w = DATAW_ALU;
        regfile_w_en       = 1'b0;
        halt               = 1'b0;
        dm_ack             = 1'b0;
    endtask

    // Presents one load/store and services the bus; ack_at = BUSY cycle index
    // that acks (-1 = never). Entered and left #1 after a rising edge.
    task automatic run_access(
        input  logic [31:0] addr, input logic [31:0] data, input logic [2:0] op,
        input  logic we, input int ack_at, input logic [31:0] rdata,
        output int n_cyc, output int n_stall, output int n_req,
        output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ad,
        output logic wev, output logic [31:0] wbd, output logic wbe, output logic berr);
        bit seen_req = 1'b0;
        bit done = 1'b0;
        n_cyc = 0; n_stall = 0; n_req = 0;
        be = '0; wd = '0; ad = '0; wev = 1'b0; wbd = '0; wbe = 1'b0; berr = 1'b0;
        alu_data_res       = addr;
        regfile_data_b     = data;
        datamem_op         = op;
        datamem_w_en       = we;
        mux_regfile_data_w = we ? DATAW_ALU : DATAW_DM;
        regfile_w_en       = ~we;
        dm_rdata           = rdata;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            n_cyc++;
            if (stall) n_stall++;
            if (dm_req) begin
                n_req++;
                seen_req = 1'b1;
                be = dm_be; wd = dm_wdata; ad = dm_addr; wev = dm_we;
                dm_ack = ((n_req - 1) == ack_at);
            end else begin
                dm_ack = 1'b0;
                if (seen_req) begin
                    wbd = wb_data; wbe = wb_w_en; berr = bus_err;
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("access_completes", 32'd0, 32'd1);
        set_nop();
    endtask

    int          n_cyc, n_stall, n_req;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_ad, o_wbd;
    logic        o_we, o_wbe, o_berr;

    initial begin
        rst_n    = 1'b0;
        pc_4     = 32'h0000_1004;
        dm_rdata = 32'h0;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, dm_req}, 32'd0);
        check("rst_be", {28'd0, dm_be}, 32'd0);
        check("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;

        // SW 0x100, immediate ack
        run_access(32'h100, 32'hDEADBEEF, DM_OP_WD, 1'b1, 0, 32'h0,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("sw_be", {28'd0, o_be}, 32'h0000000F);
        check("sw_addr", o_ad, 32'h100);
        check("sw_wdata", o_wd, 32'hDEADBEEF);
        check("sw_we", {31'd0, o_we}, 32'd1);
        check("sw_stall_cycles", n_stall, 32'd2);
        check("sw_total_cycles", n_cyc, 32'd3);

        // SB 0x103
        run_access(32'h103, 32'h000000A5, DM_OP_SB, 1'b1, 0, 32'h0,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("sb_be", {28'd0, o_be}, 32'h8);
        check("sb_wdata", o_wd, 32'hA5A5A5A5);
        check("sb_addr", o_ad, 32'h100);

        // SH 0x202, ack on the third BUSY cycle
        run_access(32'h202, 32'h1234BEEF, DM_OP_SH, 1'b1, 2, 32'h0,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("sh_be", {28'd0, o_be}, 32'hC);
        check("sh_wdata", o_wd, 32'hBEEFBEEF);
        check("sh_req_cycles", n_req, 32'd3);

        // Half and byte loads with extension
        run_access(32'h202, 32'h0, DM_OP_SH, 1'b0, 0, 32'h80011234,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("lh_data", o_wbd, 32'hFFFF8001);
        check("lh_wen", {31'd0, o_wbe}, 32'd1);
        check("lh_we", {31'd0, o_we}, 32'd0);
        run_access(32'h202, 32'h0, DM_OP_UH, 1'b0, 0, 32'h80011234,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("lhu_data", o_wbd, 32'h00008001);
        run_access(32'h201, 32'h0, DM_OP_SB, 1'b0, 0, 32'h123480FF,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("lb_data", o_wbd, 32'hFFFFFF80);
        run_access(32'h201, 32'h0, DM_OP_UB, 1'b0, 0, 32'h123480FF,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("lbu_data", o_wbd, 32'h00000080);
        run_access(32'h204, 32'h0, DM_OP_WD, 1'b0, 1, 32'hCAFEF00D,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("lw_data", o_wbd, 32'hCAFEF00D);
        check("lw_addr", o_ad, 32'h204);

        // Ack timeout
        run_access(32'h300, 32'h0, DM_OP_WD, 1'b0, -1, 32'h55555555,
                   n_cyc, n_stall, n_req, o_be, o_wd, o_ad, o_we, o_wbd, o_wbe, o_berr);
        check("to_req_cycles", n_req, 32'd16);
        check("to_bus_err", {31'd0, o_berr}, 32'd1);
        check("to_wb_data", o_wbd, 32'h0);
        check("to_wb_wen", {31'd0, o_wbe}, 32'd0);
        @(negedge clk);
        check("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;

        // Misaligned LW at 0x101
        alu_data_res = 32'h101; datamem_op = DM_OP_WD;
        mux_regfile_data_w = DATAW_DM; regfile_w_en = 1'b1;
        @(negedge clk);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_stall", {31'd0, stall}, 32'd0);
        check("mis_wen", {31'd0, wb_w_en}, 32'd0);
        @(posedge clk); #1;
        check("mis_no_req", {31'd0, dm_req}, 32'd0);
        set_nop();
        @(negedge clk);
        check("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
        @(posedge clk); #1;

        // Ack outside BUSY has no effect
        dm_ack = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        check("stray_ack_req", {31'd0, dm_req}, 32'd0);
        check("stray_ack_stall", {31'd0, stall}, 32'd0);

        // Reset during BUSY
        alu_data_res = 32'h300; datamem_op = DM_OP_WD;
        mux_regfile_data_w = DATAW_DM; regfile_w_en = 1'b1;
        @(posedge clk); #1;
        check("busy_req", {31'd0, dm_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, dm_req}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_nop();
        alu_data_res = 32'h12345678; regfile_w_en = 1'b1;
        @(negedge clk);
        check("alu_pass_data", wb_data, 32'h12345678);
        check("alu_pass_stall", {31'd0, stall}, 32'd0);
        check("alu_pass_wen", {31'd0, wb_w_en}, 32'd1);
        mux_regfile_data_w = DATAW_PC4;
        #1;
        check("pc4_pass_data", wb_data, 32'h00001004);
        @(posedge clk); #1;

        // Halt is sticky and blocks later accesses
        set_nop();
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        check("halted_set", {31'd0, halted}, 32'd1);
        alu_data_res = 32'h400; mux_regfile_data_w = DATAW_DM; regfile_w_en = 1'b1;
        @(negedge clk);
        check("halted_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("halted_no_req", {31'd0, dm_req}, 32'd0);
        check("halted_sticky", {31'd0, halted}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage core. It consumes the EX/MEM pipeline register outputs and performs loads and stores against an external data-memory bus with a req/ack handshake.
- Loads and stores take a variable number of cycles, so the block drives a pipeline stall that freezes the upstream stage registers.
- It produces the final write-back data (ALU result, load data or PC+4) for the MEM/WB register.
- It handles sub-word access (byte enables, sign/zero extension), detects misalignment, and times out a bus that never acknowledges.

Parameters:
- DM_ADDR_BIT, 32, byte-address width presented on dm_addr.
- ACK_TIMEOUT, 16, maximum BUSY cycles spent waiting for dm_ack before a bus error is declared (≥2).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_4  in  IM_ADDR_BIT  PC+4 from EX/MEM register
- alu_data_res  in  32  ALU result / effective byte address
- regfile_data_b  in  32  store data
- datamem_op  in  DM_OP_BIT  access width/sign (WD, UH, SH, UB, SB)
- datamem_w_en  in  1  store request
- mux_regfile_data_w  in  MUX_RF_DATAW_BIT  write-back source (ALU, DM, PC4); a load is DM
- regfile_w_en  in  1  instruction writes the register file
- halt  in  1  halt instruction in this stage
- stall  out  1  freeze upstream pipeline registers (en = !stall)
- wb_data  out  32  write-back data
- wb_w_en  out  1  qualified register-file write enable
- dm_req  out  1  bus request
- dm_we  out  1  bus write
- dm_addr  out  DM_ADDR_BIT  word-aligned address ({addr[31:2],2'b00})
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-aligned store data
- dm_ack  in  1  bus completion, single-cycle pulse
- dm_rdata  in  32  read data, valid with dm_ack
- misalign_err  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on an ack timeout
- halted  out  1  sticky halt indicator

Behaviour:
- Access condition: access = (datamem_w_en | mux_regfile_data_w==DATAW_DM) & !halted & aligned.
- Alignment:
  - WD requires addr[1:0]==0.
  - UH/SH require addr[0]==0.
  - Bytes are always aligned.
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE.
- Reset outputs: stall=0, dm_req=0, dm_we=0, dm_be=0, misalign_err=0, bus_err=0, halted=0, timeout counter=0, read-data register=0.
- IDLE:
  - If access: stall=1, next state BUSY.
  - Otherwise: stall=0 and wb_data passes through combinationally (ALU or PC4 source).
- BUSY:
  - dm_req=1 and stall=1; dm_we, dm_be, dm_addr and dm_wdata are held from the current inputs, which the stall keeps stable.
  - On dm_ack: capture the extracted load data and go to DONE.
  - Counter increments each BUSY cycle. When it reaches ACK_TIMEOUT-1 with no ack: go to DONE with the error flag set.
  - Minimum latency is 3 cycles per access (IDLE, BUSY, DONE).
- DONE:
  - stall=0; wb_data = captured data (0 on error). Next state IDLE.
  - bus_err pulses in this cycle if a timeout occurred; wb_w_en=0 in that case.
- dm_req is a pure decode of state==BUSY, so the request drops as soon as the FSM leaves BUSY.
- Stores:
  - WD: be=1111, wdata=data.
  - Half: be = addr[1] ? 1100 : 0011, wdata={2{data[15:0]}}.
  - Byte: be = 0001<<addr[1:0], wdata={4{data[7:0]}}.
- Loads: the lane selected by addr[1:0] is extracted; SH/SB sign-extend, UH/UB zero-extend.
- Misaligned access:
  - No bus request; stall=0.
  - misalign_err=1 for that single cycle.
  - wb_w_en=0 and the store is suppressed.
- wb_w_en = regfile_w_en, except forced 0 on misalignment or on a bus error in DONE.
- halt=1 in IDLE sets halted (sticky until reset). Once halted, no further access starts.
- dm_ack arriving outside BUSY is ignored.
- Reset mid-operation: state goes to IDLE immediately, so dm_req drops asynchronously and the pending access is abandoned.

Decomposition:
- Shared package/header (extends Core.vh) holds:
  - DM_OP_* encodings and DM_OP_BIT.
  - MUX_RF_DATAW_* encodings.
  - FSM state encodings.
- One natural combinational sub-module, dm_lane_align: given addr[1:0], op, store data and raw read data, it produces be, wdata and extended load data.

Test Plan:
- SW to addr 0x100, data 0xDEADBEEF, ack in the first BUSY cycle -> dm_be=1111, dm_addr=0x100, stall high for 2 cycles, total 3 cycles.
- SB to addr 0x103, data 0x000000A5 -> dm_be=1000, dm_wdata=0xA5A5A5A5.
- LH at 0x202 with rdata 0x8001xxxx -> wb_data=0xFFFF8001. LHU at the same address -> 0x00008001.
- LW at 0x101 -> misalign_err 1-cycle pulse, dm_req never asserts, stall=0, wb_w_en=0.
- LW with dm_ack withheld, ACK_TIMEOUT=16 -> dm_req high for 16 cycles, then bus_err pulse in DONE, wb_data=0, wb_w_en=0.
- rst_n low during BUSY -> dm_req and stall drop immediately; after release, an ALU op in IDLE passes alu_data_res to wb_data with no stall.
